// File: rtl/minefield_pkg.sv
// Shared encodings for the minefield board engine: command ops, FSM states
// and the 8-neighbour offset table walked by flood fill and mine counting.
package minefield_pkg;

  localparam logic [1:0] OP_REVEAL     = 2'd0;
  localparam logic [1:0] OP_FLAG       = 2'd1;
  localparam logic [1:0] OP_REVEAL_ALL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_POP,
    ST_CHECK,
    ST_PUSH
  } state_t;

  // Neighbour k order: top row left to right, middle left/right, bottom row.
  localparam int NB_DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  localparam int NB_DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};

endpackage

// File: rtl/minefield_board_adj_counter.sv
// Combinational count of mines among the 8 neighbours of (x,y); neighbours
// that fall off the board edge are masked out.
module adj_counter
  import minefield_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  localparam int N_CELLS = GRID_W * GRID_H,
  localparam int A_W     = $clog2(N_CELLS)
)(
  input  logic [N_CELLS-1:0] mines,
  input  logic [X_W-1:0]     x,
  input  logic [Y_W-1:0]     y,
  output logic [3:0]         count
);

  always_comb begin
    int nx;
    int ny;
    logic [A_W-1:0] idx;
    count = '0;
    nx    = 0;
    ny    = 0;
    idx   = '0;
    for (int k = 0; k < 8; k++) begin
      nx  = int'(x) + NB_DX[k];
      ny  = int'(y) + NB_DY[k];
      idx = A_W'(ny * GRID_W + nx);
      if (nx >= 0 && nx < GRID_W && ny >= 0 && ny < GRID_H && mines[idx])
        count = count + 4'd1;
    end
  end

endmodule

// File: rtl/minefield_board.sv
// Minesweeper board engine: mine/reveal/flag maps, command execution with
// stack-based zero-cell flood fill, win/loss tracking and a registered read port.
module minefield_board
  import minefield_pkg::*;
#(
  parameter int GRID_W = 16,
  parameter int GRID_H = 16,
  parameter int X_W    = 4,
  parameter int Y_W    = 4,
  localparam int N_CELLS = GRID_W * GRID_H,
  localparam int A_W     = $clog2(N_CELLS)
)(
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           mine_wr_en,
  input  logic [A_W-1:0] mine_wr_addr,
  input  logic           mine_wr_data,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [1:0]     cmd_op,
  input  logic [X_W-1:0] cmd_x,
  input  logic [Y_W-1:0] cmd_y,
  input  logic [X_W-1:0] rd_x,
  input  logic [Y_W-1:0] rd_y,
  output logic           rd_mine,
  output logic           rd_revealed,
  output logic           rd_flag,
  output logic [3:0]     rd_count,
  output logic           busy,
  output logic           lost,
  output logic           won,
  output logic [A_W:0]   revealed_cnt,
  output logic [A_W:0]   mine_cnt
);

  localparam logic [A_W:0] N_CELLS_V = (A_W+1)'(N_CELLS);
  localparam logic [A_W:0] CNT_ONE   = (A_W+1)'(1);

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready depends only on registered state.

  logic [N_CELLS-1:0]   mine_map, rev_map, flag_map, pend_map;
  logic [X_W+Y_W-1:0]   stack_mem [N_CELLS];
  logic [A_W:0]         sp;
  state_t               state;
  logic [X_W-1:0]       cur_x;
  logic [Y_W-1:0]       cur_y;
  logic [2:0]           nb_k;
  logic [3:0]           cur_adj, rd_adj;

  logic [A_W-1:0]       cmd_idx, cur_idx, rd_idx, nb_idx, sp_top;
  logic [X_W-1:0]       nb_x;
  logic [Y_W-1:0]       nb_y;
  logic                 nb_ok, nb_push, cmd_fire;
  logic                 push_en;
  logic [X_W+Y_W-1:0]   push_data;

  function automatic logic [A_W-1:0] cell_idx(input logic [X_W-1:0] x,
                                               input logic [Y_W-1:0] y);
    return A_W'(int'(y) * GRID_W + int'(x));
  endfunction

  function automatic logic in_grid(input logic [X_W-1:0] x, input logic [Y_W-1:0] y);
    return (int'(x) < GRID_W) && (int'(y) < GRID_H);
  endfunction

  assign cmd_ready = (state == ST_IDLE) && !lost && !won;
  assign busy      = (state != ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready && in_grid(cmd_x, cmd_y);
  assign cmd_idx   = cell_idx(cmd_x, cmd_y);
  assign cur_idx   = cell_idx(cur_x, cur_y);
  assign rd_idx    = cell_idx(rd_x, rd_y);
  assign sp_top    = A_W'(sp - CNT_ONE);

  always_comb begin
    int nxi;
    int nyi;
    nxi     = int'(cur_x) + NB_DX[nb_k];
    nyi     = int'(cur_y) + NB_DY[nb_k];
    nb_ok   = nxi >= 0 && nxi < GRID_W && nyi >= 0 && nyi < GRID_H;
    nb_x    = X_W'(nxi);
    nb_y    = Y_W'(nyi);
    nb_idx  = cell_idx(nb_x, nb_y);
    nb_push = nb_ok && !rev_map[nb_idx] && !flag_map[nb_idx] && !pend_map[nb_idx];
  end

  always_comb begin
    push_en   = 1'b0;
    push_data = {nb_y, nb_x};
    if (state == ST_IDLE && cmd_fire && cmd_op == OP_REVEAL) begin
      push_en   = 1'b1;
      push_data = {cmd_y, cmd_x};
    end else if (state == ST_PUSH && nb_push) begin
      push_en = 1'b1;
    end
  end

  adj_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W)) u_adj_cur (
    .mines(mine_map), .x(cur_x), .y(cur_y), .count(cur_adj)
  );

  adj_counter #(.GRID_W(GRID_W), .GRID_H(GRID_H), .X_W(X_W), .Y_W(Y_W)) u_adj_rd (
    .mines(mine_map), .x(rd_x), .y(rd_y), .count(rd_adj)
  );

  // Stack contents need no reset: sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push_en) stack_mem[sp[A_W-1:0]] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state        <= ST_IDLE;
      mine_map     <= '0;
      rev_map      <= '0;
      flag_map     <= '0;
      pend_map     <= '0;
      sp           <= '0;
      cur_x        <= '0;
      cur_y        <= '0;
      nb_k         <= '0;
      lost         <= 1'b0;
      won          <= 1'b0;
      revealed_cnt <= '0;
      mine_cnt     <= '0;
      rd_mine      <= 1'b0;
      rd_revealed  <= 1'b0;
      rd_flag      <= 1'b0;
      rd_count     <= '0;
    end else begin
      if (in_grid(rd_x, rd_y)) begin
        rd_mine     <= mine_map[rd_idx];
        rd_revealed <= rev_map[rd_idx];
        rd_flag     <= flag_map[rd_idx];
        rd_count    <= rd_adj;
      end else begin
        rd_mine     <= 1'b0;
        rd_revealed <= 1'b0;
        rd_flag     <= 1'b0;
        rd_count    <= '0;
      end

      case (state)
        ST_IDLE: begin
          if (!lost && !won) begin
            if (mine_wr_en && int'(mine_wr_addr) < N_CELLS &&
                mine_wr_data != mine_map[mine_wr_addr]) begin
              mine_map[mine_wr_addr] <= mine_wr_data;
              mine_cnt <= mine_wr_data ? mine_cnt + CNT_ONE : mine_cnt - CNT_ONE;
            end
            if (mine_cnt != '0 && revealed_cnt == N_CELLS_V - mine_cnt)
              won <= 1'b1;
            if (cmd_fire) begin
              case (cmd_op)
                OP_REVEAL: begin
                  pend_map[cmd_idx] <= 1'b1;
                  sp                <= sp + CNT_ONE;
                  state             <= ST_POP;
                end
                OP_FLAG: begin
                  if (!rev_map[cmd_idx]) flag_map[cmd_idx] <= !flag_map[cmd_idx];
                end
                OP_REVEAL_ALL: begin
                  rev_map      <= '1;
                  revealed_cnt <= N_CELLS_V - mine_cnt;
                end
                default: ;
              endcase
            end
          end
        end
        ST_POP: begin
          if (sp == '0) begin
            state <= ST_IDLE;
          end else begin
            {cur_y, cur_x} <= stack_mem[sp_top];
            sp             <= sp - CNT_ONE;
            state          <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (flag_map[cur_idx] || rev_map[cur_idx]) begin
            state <= ST_POP;
          end else begin
            rev_map[cur_idx] <= 1'b1;
            revealed_cnt     <= revealed_cnt + CNT_ONE;
            if (mine_map[cur_idx]) begin
              lost  <= 1'b1;
              sp    <= '0;
              state <= ST_IDLE;
            end else if (cur_adj == 4'd0) begin
              nb_k  <= 3'd0;
              state <= ST_PUSH;
            end else begin
              state <= ST_POP;
            end
          end
        end
        ST_PUSH: begin
          if (nb_push) begin
            pend_map[nb_idx] <= 1'b1;
            sp               <= sp + CNT_ONE;
          end
          nb_k <= nb_k + 3'd1;
          if (nb_k == 3'd7) state <= ST_POP;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
